seq_multiplier: RTL



---
 rtl/seq_mul_pkg.sv | 19 +
 rtl/seq_multiplier_zero_flag.sv | 11 +
 rtl/seq_multiplier.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The zero-operand shortcut is selected by the SEQMUL_EARLY_EXIT_EN macro.
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for an arbitrary operand width.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_zero_flag.sv
// Combinational zero detector feeding the registered zero flag of the multiplier.
module zero_flag #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             is_zero
);

  assign is_zero = (data == '0);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one partial product per cycle.
// Define SEQMUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// in_ready and out_valid are decoded from the state register only, so neither depends
// combinationally on in_valid or out_ready.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               zf,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int CW = count_width(WIDTH);

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_zf;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_acc_zero;
  logic                 w_run_done;
  logic                 w_zero_op;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQMUL_EARLY_EXIT_EN
  assign w_zero_op  = (a == '0) || (b == '0);
  // Stop once no set multiplier bits remain after this iteration's shift.
  assign w_run_done = (r_count == CW'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_zero_op  = 1'b0;
  assign w_run_done = (r_count == CW'(WIDTH - 1));
`endif

  zero_flag #(
    .WIDTH (2*WIDTH)
  ) u_zero_flag (
    .data    (w_acc_next),
    .is_zero (w_acc_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next_state = w_zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_run_done) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_zf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_count  <= '0;
            if (w_zero_op) begin
              r_product <= '0;
              r_zf      <= 1'b1;
            end
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (w_run_done) begin
            r_product <= w_acc_next;
            r_zf      <= w_acc_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign product   = r_product;
  assign zf        = r_zf;
  assign dbg_state = r_state;

endmodule
